// File: rtl/imm_encoder.sv
// imm_encoder: packs a 64-bit immediate into the 26-bit Imm26 field and
// flags values the selected format cannot represent.
// Ports: CLK/Reset_L; in_* request (value, ctrl, base) with valid/ready;
// out_* result (imm26, err) with valid/ready; err_cnt/clr_cnt counter.
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_value,
  input  logic [2:0]       in_ctrl,
  input  logic [25:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_imm26,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  // stage A holds the raw request
  logic        a_valid;
  logic [63:0] a_value;
  logic [2:0]  a_ctrl;
  logic [25:0] a_base;

  // stage B holds the finished result
  logic        b_valid;
  logic [25:0] b_imm;
  logic        b_err;

  logic adv_b;
  logic acc_a;
  logic fire_out;

  // one-hot format decode
  logic f_i;
  logic f_d;
  logic f_b;
  logic f_cb;
  logic f_mz;

  // range predicates on the upper value bits
  logic hi12_zero;
  logic hi18_zero;
  logic hi8_same;
  logic hi18_same;
  logic hi25_same;

  logic [25:0] field;
  logic        range_err;

  assign adv_b    = !b_valid | out_ready;
  assign in_ready = !a_valid | adv_b;
  assign acc_a    = in_valid & in_ready;
  assign fire_out = b_valid & out_ready;

  always_comb begin
    f_i  = 1'b0;
    f_d  = 1'b0;
    f_b  = 1'b0;
    f_cb = 1'b0;
    f_mz = 1'b0;
    unique case (1'b1)
      (a_ctrl == 3'b000): f_i  = 1'b1;
      (a_ctrl == 3'b001): f_d  = 1'b1;
      (a_ctrl == 3'b010): f_b  = 1'b1;
      (a_ctrl == 3'b011): f_cb = 1'b1;
      a_ctrl[2]:          f_mz = 1'b1;
    endcase
  end

  // a signed n-bit value has all bits from n-1 upward equal
  assign hi12_zero = ~|a_value[63:12];
  assign hi18_zero = ~|a_value[63:18];
  assign hi8_same  = &a_value[63:8]
                   | ~|a_value[63:8];
  assign hi18_same = &a_value[63:18]
                   | ~|a_value[63:18];
  assign hi25_same = &a_value[63:25]
                   | ~|a_value[63:25];

  // the field is written with the truncated
  // value even when out of range
  always_comb begin
    field     = a_base;
    range_err = 1'b0;
    unique case (1'b1)
      f_i: begin
        field = {a_base[25:22],
                 a_value[11:0],
                 a_base[9:0]};
        range_err = !hi12_zero;
      end
      f_d: begin
        field = {a_base[25:21],
                 a_value[8:0],
                 a_base[11:0]};
        range_err = !hi8_same;
      end
      f_b: begin
        field     = a_value[25:0];
        range_err = !hi25_same;
      end
      f_cb: begin
        field = {a_base[25:24],
                 a_value[18:0],
                 a_base[4:0]};
        range_err = !hi18_same;
      end
      f_mz: begin
        field = {a_base[25:23],
                 a_value[17:0],
                 a_base[4:0]};
        range_err = !hi18_zero;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      a_valid <= 1'b0;
      a_value <= '0;
      a_ctrl  <= '0;
      a_base  <= '0;
    end else if (in_ready) begin
      a_valid <= in_valid;
      if (acc_a) begin
        a_value <= in_value;
        a_ctrl  <= in_ctrl;
        a_base  <= in_base;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      b_valid <= 1'b0;
      b_imm   <= '0;
      b_err   <= 1'b0;
    end else if (adv_b) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_imm <= field;
        b_err <= range_err;
      end
    end
  end

  // clear wins over a same-cycle increment
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (fire_out & b_err
                 & ~&err_cnt) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = b_valid;
  assign out_imm26 = b_imm;
  assign out_err   = b_err;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and random checks of imm_encoder
// against a behavioural field/range model and a result scoreboard.
module tb_imm_encoder;

  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             Reset_L = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_value = '0;
  logic [2:0]       in_ctrl = '0;
  logic [25:0]      in_base = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [25:0]      out_imm26;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;
  logic             clr_cnt = 1'b0;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .Reset_L(Reset_L),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .in_ctrl(in_ctrl),
    .in_base(in_base),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_imm26(out_imm26),
    .out_err(out_err),
    .err_cnt(err_cnt),
    .clr_cnt(clr_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [25:0] imm;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  int   exp_cnt = 0;
  bit   rnd = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  // field position/width and range rule per format
  function automatic exp_t model(
    input logic [63:0] v,
    input logic [2:0]  c,
    input logic [25:0] b);
    exp_t        r;
    int          lsb;
    int          w;
    bit          sgn;
    logic [63:0] m;
    logic [63:0] full;
    longint      sv;
    longint      lo;
    longint      hi;
    case (c)
      3'd0:    begin lsb = 10; w = 12; sgn = 0; end
      3'd1:    begin lsb = 12; w = 9;  sgn = 1; end
      3'd2:    begin lsb = 0;  w = 26; sgn = 1; end
      3'd3:    begin lsb = 5;  w = 19; sgn = 1; end
      default: begin lsb = 5;  w = 18; sgn = 0; end
    endcase
    m    = (64'd1 << w) - 64'd1;
    full = ({38'd0, b} & ~(m << lsb))
         | ((v & m) << lsb);
    r.imm = full[25:0];
    if (sgn) begin
      sv = $signed(v);
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
      r.err = (sv < lo) || (sv > hi);
    end else begin
      r.err = (v >> w) != 64'd0;
    end
    return r;
  endfunction

  // scoreboard, counter model and hold-stability monitor
  exp_t        e;
  bit          held = 1'b0;
  logic [25:0] h_imm;
  logic        h_err;
  bit          fire;
  bit          f_err;

  always @(negedge CLK) begin
    if (!Reset_L) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_err_cnt", 64'(err_cnt), 64'd0);
      exp_q.delete();
      exp_cnt = 0;
      held = 1'b0;
    end else begin
      chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
      if (held) begin
        chk("hold_imm", 64'(out_imm26), 64'(h_imm));
        chk("hold_err", 64'(out_err), 64'(h_err));
      end
      held  = out_valid && !out_ready;
      h_imm = out_imm26;
      h_err = out_err;
      fire  = out_valid && out_ready;
      f_err = 1'b0;
      if (fire) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out",
              64'(exp_q.size()), 64'd1);
          f_err = out_err;
        end else begin
          e = exp_q.pop_front();
          chk("sb_imm", 64'(out_imm26), 64'(e.imm));
          chk("sb_err", 64'(out_err), 64'(e.err));
          f_err = e.err;
        end
      end
      if (clr_cnt)
        exp_cnt = 0;
      else if (fire && f_err && exp_cnt < 255)
        exp_cnt++;
      if (in_valid && in_ready)
        exp_q.push_back(
          model(in_value, in_ctrl, in_base));
    end
  end

  // called at posedge+2; returns at posedge+2 after the
  // accepting edge with in_valid still high
  task automatic send(input logic [63:0] v,
                      input logic [2:0]  c,
                      input logic [25:0] b);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_value = v;
    in_ctrl  = c;
    in_base  = b;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      #2;
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        clr_cnt   = ($urandom_range(0, 31) == 0);
      end
    end
    chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic run1(input logic [63:0] v,
                      input logic [2:0]  c,
                      input logic [25:0] b,
                      input logic [25:0] x_imm,
                      input logic        x_err,
                      input string       tag);
    bit got;
    got = 1'b0;
    step();
    send(v, c, b);
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge CLK);
      got = out_valid;
    end
    chk({tag, "_valid"}, 64'(got), 64'd1);
    chk({tag, "_imm"}, 64'(out_imm26), 64'(x_imm));
    chk({tag, "_err"}, 64'(out_err), 64'(x_err));
  endtask

  initial begin
    int          base_out;
    int          w;
    logic [63:0] r;
    logic [63:0] m;
    logic [63:0] v;

    repeat (2) @(posedge CLK);
    #2;
    Reset_L = 1'b1;
    @(negedge CLK);
    chk("init_valid", 64'(out_valid), 64'd0);
    chk("init_imm", 64'(out_imm26), 64'd0);
    chk("init_err", 64'(out_err), 64'd0);
    chk("init_ready", 64'(in_ready), 64'd1);

    // latency: valid appears on the second edge
    step();
    send(64'h123, 3'd0, 26'd0);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("lat_early", 64'(out_valid), 64'd0);
    @(negedge CLK);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_imm", 64'(out_imm26), 64'h048C00);
    chk("lat_err", 64'(out_err), 64'd0);

    run1(64'h1000, 3'd0, 26'd0,
         26'h0, 1'b1, "i_over");
    run1(64'd0, 3'd0, 26'h3FFFFFF,
         26'h3C003FF, 1'b0, "i_base");
    run1(-64'sd4, 3'd1, 26'h3FF,
         26'h1FC3FF, 1'b0, "d_neg4");
    run1(64'd255, 3'd1, 26'd0,
         26'h0FF000, 1'b0, "d_255");
    run1(64'd256, 3'd1, 26'd0,
         26'h100000, 1'b1, "d_256");
    run1(-64'sd256, 3'd1, 26'd0,
         26'h100000, 1'b0, "d_m256");
    run1(-64'sd257, 3'd1, 26'd0,
         26'h0FF000, 1'b1, "d_m257");
    run1(-64'sd1, 3'd2, 26'h155,
         26'h3FFFFFF, 1'b0, "b_m1");
    run1(64'h2000000, 3'd2, 26'd0,
         26'h2000000, 1'b1, "b_over");
    run1(64'h3FFFF, 3'd3, 26'd0,
         26'h7FFFE0, 1'b0, "cb_max");
    run1(64'h3FFFF, 3'd4, 26'd0,
         26'h7FFFE0, 1'b0, "mz_max");
    run1(-64'sd1, 3'd7, 26'h3FFFFFF,
         26'h3FFFFFF, 1'b1, "mz_neg");

    // backpressure: two accepted, then stall
    step();
    out_ready = 1'b0;
    send(64'd1, 3'd1, 26'd0);
    send(64'd2, 3'd1, 26'd1);
    in_value = 64'd3;
    in_base  = 26'd2;
    @(negedge CLK);
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_valid", 64'(out_valid), 64'd1);
    step();
    @(negedge CLK);
    chk("bp_ready2", 64'(in_ready), 64'd0);
    step();
    base_out = n_out;
    out_ready = 1'b1;
    send(64'd3, 3'd1, 26'd2);
    send(64'd4, 3'd1, 26'd3);
    in_valid = 1'b0;
    repeat (6) step();
    chk("bp_count", 64'(n_out - base_out), 64'd4);

    // saturating counter
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int i = 0; i < 257; i++)
      send(64'h1000, 3'd0, 26'd0);
    in_valid = 1'b0;
    repeat (4) step();
    @(negedge CLK);
    chk("cnt_sat", 64'(err_cnt), 64'd255);

    // clear coincides with an erroneous transfer
    step();
    send(64'h1000, 3'd0, 26'd0);
    in_valid = 1'b0;
    step();
    clr_cnt = 1'b1;
    @(negedge CLK);
    chk("clr_same_valid", 64'(out_valid), 64'd1);
    step();
    clr_cnt = 1'b0;
    @(negedge CLK);
    chk("clr_prio", 64'(err_cnt), 64'd0);

    // reset with both stages full and stalled
    step();
    send(64'h1000, 3'd0, 26'd0);
    in_valid = 1'b0;
    repeat (3) step();
    @(negedge CLK);
    chk("cnt_pre_rst", 64'(err_cnt), 64'd1);
    step();
    out_ready = 1'b0;
    send(64'h5, 3'd0, 26'd0);
    send(64'h6, 3'd0, 26'd0);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("full_ready", 64'(in_ready), 64'd0);
    step();
    Reset_L = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_cnt", 64'(err_cnt), 64'd0);
    step();
    Reset_L = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    send(64'h123, 3'd0, 26'd0);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("no_stale", 64'(out_valid), 64'd0);
    @(negedge CLK);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_imm", 64'(out_imm26), 64'h048C00);

    // random traffic with random stalls and clears
    step();
    rnd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w = $urandom_range(1, 64);
      r = {$urandom, $urandom};
      if (w == 64) begin
        v = r;
      end else begin
        m = (64'd1 << w) - 64'd1;
        v = r & m;
        if (r[w-1])
          v = v | ~m;
      end
      send(v, 3'($urandom_range(0, 7)),
           26'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    rnd = 1'b0;
    clr_cnt = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
